mem_access_ctrl: RTL and testbench

Memory-stage controller for each core's five-stage pipeline. It sits between the EX/MEM latch and the MEM/WB latch and drives the core's dcache request port. It holds a load/store request until `dhit`, and stalls the pipeline while the cache is busy. It captures load data when the hit arrives and produces the values that feed the MEM/WB latch inputs. It also implements LL/SC with a per-core link register that coherence snoops invalidate.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/mem_access_ctrl_link_reg.sv | 48 ++++
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core types for the memory stage.
// Word type, memory-stage FSM states and a word-address compare helper.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } mem_state_t;

    // Same 32-bit word: ignore the byte offset bits.
    function automatic logic word_match(input word_t a, input word_t b);
        return ((a ^ b) >> 2) == '0;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_link_reg.sv
// LL/SC link register with snoop and local-store invalidation.
// Reports whether an SC to chk_addr may proceed this cycle.
module link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set_en,
    input  word_t set_addr,
    input  logic  clr_en,
    input  logic  st_en,
    input  word_t st_addr,
    input  logic  ccinv,
    input  word_t snoop_addr,
    input  word_t chk_addr,
    output logic  sc_ok
);

    logic  link_valid;
    word_t link_addr;
    logic  inv_cur;
    logic  inv_set;
    logic  st_hit;

    // Invalidate/match terms; a snoop to the word being linked wins.
    always_comb begin
        inv_cur = ccinv && word_match(snoop_addr, link_addr);
        inv_set = ccinv && word_match(snoop_addr, set_addr);
        st_hit  = st_en && word_match(st_addr, link_addr);
        sc_ok   = link_valid
                  && word_match(link_addr, chk_addr)
                  && !(ccinv && word_match(snoop_addr, chk_addr));
    end

    // Link state: LL sets, SC/snoop/local store clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set_en) begin
            link_addr  <= set_addr;
            link_valid <= !inv_set;
        end else if (clr_en || inv_cur || st_hit) begin
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: dcache request, stall, load capture, LL/SC.
// Requests go out combinationally in IDLE and are replayed from registers.
module mem_access_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
)
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dREN_i,
    input  logic  dWEN_i,
    input  logic  atomic_i,
    input  word_t addr_i,
    input  word_t store_i,
    input  logic  advance_i,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  ccinv,
    input  word_t ccsnoopaddr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output word_t load_o,
    output word_t sc_result_o
);

    mem_state_t state;
    mem_state_t next_state;

    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] store_q;
    logic [WORD_W-1:0] load_q;
    logic ren_q;
    logic wen_q;
    logic ll_q;
    logic sc_q;
    logic sc_res_q;

    logic  is_ll;
    logic  is_sc;
    logic  mem_op;
    logic  sc_ok;
    logic  sc_fail;
    logic  ren;
    logic  wen;
    logic  stall;
    logic  ll_now;
    logic  sc_now;
    word_t addr;
    word_t wdata;
    logic  ld_hit;
    logic  sc_out;
    word_t load_mux;
    logic  sc_eval;

    // Next state and request: live inputs in IDLE, replayed copy in ACCESS.
    always_comb begin
        is_ll      = dREN_i & atomic_i;
        is_sc      = dWEN_i & atomic_i & ~dREN_i;
        mem_op     = dREN_i | dWEN_i;
        sc_fail    = is_sc & ~sc_ok;
        next_state = state;
        ren        = 1'b0;
        wen        = 1'b0;
        addr       = '0;
        wdata      = '0;
        stall      = 1'b0;
        ll_now     = 1'b0;
        sc_now     = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_op && !sc_fail) begin
                    ren    = dREN_i;
                    wen    = dWEN_i & ~dREN_i;
                    addr   = addr_i;
                    wdata  = store_i;
                    ll_now = is_ll;
                    sc_now = is_sc;
                    if (!dhit) begin
                        stall      = 1'b1;
                        next_state = ACCESS;
                    end else if (!advance_i) begin
                        next_state = HOLD;
                    end
                end else if (sc_fail && !advance_i) begin
                    next_state = HOLD;
                end
            end
            ACCESS: begin
                ren    = ren_q;
                wen    = wen_q;
                addr   = addr_q;
                wdata  = store_q;
                ll_now = ll_q;
                sc_now = sc_q;
                if (dhit) begin
                    next_state = advance_i ? IDLE : HOLD;
                end else begin
                    stall = 1'b1;
                end
            end
            HOLD: begin
                if (advance_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output muxing; everything is forced low while reset is held.
    always_comb begin
        sc_eval     = (state == IDLE) && is_sc;
        ld_hit      = ren & dhit;
        load_mux    = ld_hit ? dmemload : load_q;
        sc_out      = sc_eval ? sc_ok : sc_res_q;
        dmemREN     = nRST & ren;
        dmemWEN     = nRST & wen;
        dmemaddr    = nRST ? addr : '0;
        dmemstore   = nRST ? wdata : '0;
        mem_stall   = nRST & stall;
        load_o      = nRST ? load_mux : '0;
        sc_result_o = nRST ? {31'd0, sc_out} : '0;
    end

    // State, replay copy of the request, captured load and SC outcome.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            addr_q   <= '0;
            store_q  <= '0;
            load_q   <= '0;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            ll_q     <= 1'b0;
            sc_q     <= 1'b0;
            sc_res_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE) begin
                ren_q   <= ren;
                wen_q   <= wen;
                ll_q    <= ll_now;
                sc_q    <= sc_now;
                addr_q  <= addr;
                store_q <= wdata;
            end
            if (ld_hit) begin
                load_q <= dmemload;
            end
            if (sc_eval) begin
                sc_res_q <= sc_ok;
            end
        end
    end

    link_reg u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_en     (ren & dhit & ll_now),
        .set_addr   (addr),
        .clr_en     (sc_eval),
        .st_en      (wen & dhit & ~sc_now),
        .st_addr    (addr),
        .ccinv      (ccinv),
        .snoop_addr (ccsnoopaddr),
        .chk_addr   (addr_i),
        .sc_ok      (sc_ok)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios then random ops
// checked against a transaction-level LL/SC and latency model.
module tb_mem_access_ctrl;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  dREN_i, dWEN_i, atomic_i, advance_i, dhit, ccinv;
    word_t addr_i, store_i, dmemload, ccsnoopaddr;
    logic  dmemREN, dmemWEN, mem_stall;
    word_t dmemaddr, dmemstore, load_o, sc_result_o;

    int n_chk = 0;
    int n_fail = 0;

    logic  lv_m;
    word_t la_m;
    word_t pool [4] = '{32'h100, 32'h200, 32'h300, 32'h304};

    mem_access_ctrl #(.WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .dREN_i(dREN_i), .dWEN_i(dWEN_i), .atomic_i(atomic_i),
        .addr_i(addr_i), .store_i(store_i), .advance_i(advance_i),
        .dhit(dhit), .dmemload(dmemload),
        .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .load_o(load_o),
        .sc_result_o(sc_result_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic same_word(input word_t a, input word_t b);
        return (a / 4) == (b / 4);
    endfunction

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        dREN_i = 0; dWEN_i = 0; atomic_i = 0;
        addr_i = 0; store_i = 0; advance_i = 1;
        dhit = 0; dmemload = 0; ccinv = 0; ccsnoopaddr = 0;
    endtask

    // kind: 0 load, 1 store, 2 LL, 3 SC; lat = cycles before dhit
    task automatic op(input int kind, input word_t a, input word_t d,
                      input word_t rd, input int lat, input int hold,
                      input logic inv, input word_t inv_a);
        logic is_ld, is_sc, ok, do_req;
        int   le;
        is_ld  = (kind == 0) || (kind == 2);
        is_sc  = (kind == 3);
        ok     = lv_m && same_word(la_m, a) && !(inv && same_word(inv_a, a));
        do_req = !is_sc || ok;
        le     = do_req ? lat : 0;
        dREN_i = is_ld; dWEN_i = !is_ld; atomic_i = (kind >= 2);
        addr_i = a; store_i = d;
        for (int c = 0; c <= le; c++) begin
            dhit        = do_req && (c == le);
            dmemload    = (c == le) ? rd : $urandom;
            advance_i   = (c == le) && (hold == 0);
            ccinv       = inv && (is_sc ? (c == 0) : (c == le));
            ccsnoopaddr = inv_a;
            @(negedge CLK);
            chk("ren", dmemREN, do_req && is_ld);
            chk("wen", dmemWEN, do_req && !is_ld);
            if (do_req) chk("addr", dmemaddr, a);
            if (do_req && !is_ld) chk("wdata", dmemstore, d);
            chk("stall", mem_stall, c < le);
            if (c == le && is_ld) chk("load_hit", load_o, rd);
            if (c == le && is_sc) chk("sc_done", sc_result_o, ok);
            next_cycle();
        end
        dhit = 0; ccinv = 0; dmemload = $urandom;
        if (kind == 2) begin la_m = a; lv_m = 1; end
        if (kind == 1 && same_word(a, la_m)) lv_m = 0;
        if (is_sc) lv_m = 0;
        if (inv && same_word(inv_a, la_m)) lv_m = 0;
        for (int h = 0; h < hold; h++) begin
            advance_i = (h == hold - 1);
            @(negedge CLK);
            chk("hold_ren", dmemREN, 0);
            chk("hold_wen", dmemWEN, 0);
            chk("hold_stall", mem_stall, 0);
            if (is_ld) chk("hold_load", load_o, rd);
            if (is_sc) chk("hold_sc", sc_result_o, ok);
            next_cycle();
        end
        clear_inputs();
    endtask

    task automatic idle(input logic inv, input word_t inv_a);
        clear_inputs();
        ccinv = inv; ccsnoopaddr = inv_a;
        @(negedge CLK);
        chk("idle_ren", dmemREN, 0);
        chk("idle_wen", dmemWEN, 0);
        chk("idle_stall", mem_stall, 0);
        next_cycle();
        if (inv && same_word(inv_a, la_m)) lv_m = 0;
        clear_inputs();
    endtask

    initial begin
        lv_m = 0; la_m = 0;
        clear_inputs();
        nRST = 0;
        dREN_i = 1; addr_i = 32'h100;
        next_cycle();
        @(negedge CLK);
        chk("rst_ren", dmemREN, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_addr", dmemaddr, 0);
        chk("rst_load", load_o, 0);
        chk("rst_sc", sc_result_o, 0);
        next_cycle();
        clear_inputs();
        nRST = 1;
        next_cycle();

        op(0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 0);
        op(1, 32'h200, 32'h1234, 0, 3, 0, 0, 0);
        op(0, 32'h104, 0, 32'hCAFE0001, 0, 2, 0, 0);
        idle(0, 0);
        op(2, 32'h300, 0, 32'h55, 0, 0, 0, 0);
        op(3, 32'h300, 7, 0, 1, 1, 0, 0);
        op(3, 32'h300, 7, 0, 0, 0, 0, 0);
        op(2, 32'h300, 0, 32'h66, 2, 0, 0, 0);
        idle(1, 32'h302);
        op(3, 32'h300, 7, 0, 0, 1, 0, 0);
        op(2, 32'h300, 0, 32'h77, 0, 0, 1, 32'h301);
        op(3, 32'h300, 9, 0, 0, 0, 0, 0);
        op(2, 32'h304, 0, 32'h88, 1, 0, 0, 0);
        op(1, 32'h306, 32'h99, 0, 0, 0, 0, 0);
        op(3, 32'h304, 5, 0, 0, 0, 0, 0);

        op(2, 32'h300, 0, 32'h11, 0, 0, 0, 0);
        dREN_i = 1; addr_i = 32'h100; advance_i = 0;
        @(negedge CLK);
        chk("miss_stall", mem_stall, 1);
        next_cycle();
        @(negedge CLK);
        chk("acc_ren", dmemREN, 1);
        chk("acc_stall", mem_stall, 1);
        next_cycle();
        nRST = 0;
        next_cycle();
        @(negedge CLK);
        chk("rst2_ren", dmemREN, 0);
        chk("rst2_stall", mem_stall, 0);
        chk("rst2_load", load_o, 0);
        chk("rst2_sc", sc_result_o, 0);
        next_cycle();
        clear_inputs();
        nRST = 1;
        lv_m = 0;
        next_cycle();
        op(3, 32'h300, 3, 0, 0, 0, 0, 0);
        op(0, 32'h200, 0, 32'h12345678, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int    k;
            word_t a;
            k = $urandom % 4;
            a = pool[$urandom % 4];
            if (k == 3 && lv_m && ($urandom % 2)) a = la_m;
            op(k, a, $urandom, $urandom, $urandom % 4, $urandom % 3,
               ($urandom % 6) == 0, pool[$urandom % 4] | ($urandom % 4));
            idle(($urandom % 4) == 0, pool[$urandom % 4] | ($urandom % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
